// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-unit bundle: pipeline-register fields seen by the unit and the
// enables it drives back into the PC, IF/ID, ID/EX and the later stages.
interface pipeline_hazard_ctrl_if;
   logic [4:0] ifid_rs;
   logic [4:0] ifid_rt;
   logic       ifid_uses_rt;
   logic       ifid_jr;
   logic       idex_memread;
   logic       idex_regwrite;
   logic       idex_regdst;
   logic       idex_jal;
   logic [4:0] idex_rt;
   logic [4:0] idex_rd;
   logic       exmem_regwrite;
   logic [4:0] exmem_dest;
   logic       ex_redirect;
   logic       mem_busy;
   logic       pc_write;
   logic       ifid_write;
   logic       ifid_flush;
   logic       idex_flush;
   logic       freeze;

   modport master (
      output ifid_rs, ifid_rt, ifid_uses_rt, ifid_jr,
             idex_memread, idex_regwrite, idex_regdst, idex_jal, idex_rt, idex_rd,
             exmem_regwrite, exmem_dest, ex_redirect, mem_busy,
      input  pc_write, ifid_write, ifid_flush, idex_flush, freeze
   );

   modport slave (
      input  ifid_rs, ifid_rt, ifid_uses_rt, ifid_jr,
             idex_memread, idex_regwrite, idex_regdst, idex_jal, idex_rt, idex_rd,
             exmem_regwrite, exmem_dest, ex_redirect, mem_busy,
      output pc_write, ifid_write, ifid_flush, idex_flush, freeze
   );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and pipeline-control unit for the 5-stage MIPS pipeline, with an
// action register and saturating stall/flush/freeze performance counters.
module pipeline_hazard_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   pipeline_hazard_ctrl_if.slave hz,
   input  logic                 perf_clr,
   output logic [1:0]           state,
   output logic [CNT_W-1:0]     stall_cycles,
   output logic [CNT_W-1:0]     flush_events,
   output logic [CNT_W-1:0]     freeze_cycles
);

   typedef enum logic [1:0] {
      ACT_RUN    = 2'd0,
      ACT_STALL  = 2'd1,
      ACT_FLUSH  = 2'd2,
      ACT_FREEZE = 2'd3
   } action_t;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [4:0] idex_dest;
   logic       load_use;
   logic       jr_haz;
   logic       stall_req;
   action_t    action;
   action_t    last_action;

   assign idex_dest = hz.idex_jal ? 5'd31 : (hz.idex_regdst ? hz.idex_rd : hz.idex_rt);

   assign load_use = hz.idex_memread & (idex_dest != 5'd0) &
                     ((idex_dest == hz.ifid_rs) | (hz.ifid_uses_rt & (idex_dest == hz.ifid_rt)));

   // jr reads rs in ID, so it must wait for producers in both EX and MEM.
   assign jr_haz = hz.ifid_jr &
                   ((hz.idex_regwrite & (idex_dest != 5'd0) & (idex_dest == hz.ifid_rs)) |
                    (hz.exmem_regwrite & (hz.exmem_dest != 5'd0) & (hz.exmem_dest == hz.ifid_rs)));

   assign stall_req = load_use | jr_haz;

   always_comb begin
      action = ACT_RUN;
      if (hz.mem_busy)
         action = ACT_FREEZE;
      else if (hz.ex_redirect)
         action = ACT_FLUSH;
      else if (stall_req)
         action = ACT_STALL;
   end

   // Enables are combinational so they gate the very next edge; reset forces them low.
   assign hz.pc_write   = reset & ((action == ACT_RUN) | (action == ACT_FLUSH));
   assign hz.ifid_write = reset & ((action == ACT_RUN) | (action == ACT_FLUSH));
   assign hz.ifid_flush = reset & (action == ACT_FLUSH);
   assign hz.idex_flush = reset & ((action == ACT_FLUSH) | (action == ACT_STALL));
   assign hz.freeze     = reset & (action == ACT_FREEZE);

   assign state = last_action;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_action   <= ACT_RUN;
         stall_cycles  <= '0;
         flush_events  <= '0;
         freeze_cycles <= '0;
      end else begin
         last_action <= action;
         if (perf_clr) begin
            stall_cycles  <= '0;
            flush_events  <= '0;
            freeze_cycles <= '0;
         end else begin
            if ((action == ACT_STALL) && (stall_cycles != CNT_MAX))
               stall_cycles <= stall_cycles + CNT_ONE;
            // A run of back-to-back FLUSH cycles is one redirect event.
            if ((action == ACT_FLUSH) && (last_action != ACT_FLUSH) && (flush_events != CNT_MAX))
               flush_events <= flush_events + CNT_ONE;
            if ((action == ACT_FREEZE) && (freeze_cycles != CNT_MAX))
               freeze_cycles <= freeze_cycles + CNT_ONE;
         end
      end
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and pipeline-control unit for the 5-stage MIPS pipeline. It reads the registered outputs of the ID/EX stage register, the destination fields of EX/MEM and the instruction currently in IF/ID. From these it drives the PC, IF/ID and ID/EX control lines: write-enables, bubble insertion and flushes. A small action FSM tracks the last cycle's action and feeds saturating performance counters for stall, flush and freeze events.

## Interface
Parameters:
- CNT_W, 16, width of each performance counter

Ports:
- clk  in  1  pipeline clock
- reset  in  1  reset, asynchronous, active-low
- ifid_rs  in  5  rs field of instruction in ID
- ifid_rt  in  5  rt field of instruction in ID
- ifid_uses_rt  in  1  ID instruction reads rt (R-type, beq/bne, sw)
- ifid_jr  in  1  ID instruction is jr
- idex_memread  in  1  MemRead output of ID/EX
- idex_regwrite  in  1  RegWrite output of ID/EX
- idex_regdst  in  1  RegDst output of ID/EX
- idex_jal  in  1  Jal output of ID/EX
- idex_rt  in  5  rt output of ID/EX
- idex_rd  in  5  rd output of ID/EX
- exmem_regwrite  in  1  RegWrite of EX/MEM
- exmem_dest  in  5  destination register of EX/MEM
- ex_redirect  in  1  taken branch or jump resolved in EX this cycle
- mem_busy  in  1  data memory not ready; pipeline must hold
- perf_clr  in  1  synchronous clear of all counters
- pc_write  out  1  PC register load enable
- ifid_write  out  1  IF/ID load enable
- ifid_flush  out  1  IF/ID loads NOP
- idex_flush  out  1  ID/EX loads all-zero control (bubble)
- freeze  out  1  hold enable for ID/EX, EX/MEM and MEM/WB
- state  out  2  registered last action: 0 RUN, 1 STALL, 2 FLUSH, 3 FREEZE
- stall_cycles  out  CNT_W  cycles spent in STALL
- flush_events  out  CNT_W  number of distinct redirect flushes
- freeze_cycles  out  CNT_W  cycles spent in FREEZE

## Operation
- The ID/EX destination is computed internally as idex_dest = idex_jal ? 31 : (idex_regdst ? idex_rd : idex_rt).
- Load-use hazard: load_use = idex_memread & (idex_dest != 0) & (idex_dest == ifid_rs | (ifid_uses_rt & idex_dest == ifid_rt)).
- jr hazard: jr_haz = ifid_jr & ((idex_regwrite & idex_dest != 0 & idex_dest == ifid_rs) | (exmem_regwrite & exmem_dest != 0 & exmem_dest == ifid_rs)).
- stall_req = load_use | jr_haz.
- Actions are evaluated in priority order FREEZE > FLUSH > STALL > RUN:
  - FREEZE (mem_busy=1): pc_write=0, ifid_write=0, ifid_flush=0, idex_flush=0, freeze=1. A pending redirect or stall is re-evaluated once mem_busy drops; inputs are stable because the stages are held.
  - FLUSH (ex_redirect=1): pc_write=1, ifid_write=1, ifid_flush=1, idex_flush=1, freeze=0. Any simultaneous stall_req is discarded, because the ID instruction is killed.
  - STALL (stall_req=1): pc_write=0, ifid_write=0, ifid_flush=0, idex_flush=1, freeze=0.
  - RUN: pc_write=1, ifid_write=1, flushes=0, freeze=0.
- The action FSM registers the current action into state on each posedge clk.
- Counters update on posedge clk:
  - stall_cycles increments in every cycle whose action is STALL.
  - freeze_cycles increments in every cycle whose action is FREEZE.
  - flush_events increments only when the action is FLUSH and state != FLUSH. Consecutive FLUSH cycles, which should not occur, count once.
  - All counters saturate at 2^CNT_W-1.
  - perf_clr=1 zeroes all counters in that cycle and has priority over increment. state is unaffected.
- The $0 register never causes a hazard.

## Timing
- Control outputs are combinational from the current inputs, so they take effect at the same posedge. Latency from hazard to gated enable is 0 cycles.
- A load-use hazard produces exactly 1 stall cycle: after the bubble, ID/EX MemRead=0.
- jr after an ALU producer: 2 stall cycles, while the producer is in EX and then in MEM.
- jr after a load: 2 stall cycles.
- Reset asserted (reset=0), asynchronously:
  - pc_write=0, ifid_write=0, ifid_flush=0, idex_flush=0, freeze=0.
  - state=0, all counters=0.
- Reset deasserted: normal evaluation resumes from the first posedge.
- Reset asserted mid-stall or mid-freeze: the unit returns to the above values immediately, and no partial count is kept.

## Test plan
- lw $8 in ID/EX (memread=1, regdst=0, rt=8), add using rs=8 in ID -> one cycle with pc_write=0, ifid_write=0, idex_flush=1; next cycle RUN; stall_cycles=1.
- Same lw, but ID instruction uses rt=8 with ifid_uses_rt=0 -> no stall. With destination $0 -> no stall.
- jr $31 in ID behind jal in ID/EX (jal=1) -> STALL; then exmem_dest=31, regwrite=1 -> STALL; then RUN; stall_cycles=2.
- ex_redirect=1 together with a load-use hazard -> ifid_flush=1, idex_flush=1, pc_write=1; flush_events increments by 1.
- mem_busy=1 for 3 cycles during a redirect -> freeze=1, all enables 0, freeze_cycles=3. After release, one FLUSH cycle; flush_events increments by 1.
- Counter with CNT_W=4 driven through 20 stall cycles -> holds 15. perf_clr -> 0. Async reset mid-freeze -> all outputs at reset values before the next clk edge.
